// File: rtl/regfile_scan_hex.sv
// Parametrised register file with one synchronous write port, one combinational read port and a
// registered 7-segment inspection path fed by an auto-scanner. Optional macro: REGFILE_WR_BYPASS_EN.
module regfile_scan_hex #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int SCAN_DIV = 4
) (
    input  logic                            clock,
    input  logic                            clrn,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [ADDR_W-1:0]               rd_addr,
    input  logic                            scan_en,
    output logic [DATA_W-1:0]               rd_data,
    output logic [ADDR_W-1:0]               scan_addr,
    output logic                            scan_tick,
    output logic [7*(DATA_W/4)-1:0]         data_hex,
    output logic [7*((ADDR_W+3)/4)-1:0]     addr_hex
);

    localparam int DATA_DIG = DATA_W / 4;
    localparam int ADDR_DIG = (ADDR_W + 3) / 4;
    localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [ADDR_W:0]        DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]      LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [7*DATA_DIG-1:0]  DATA_HEX_RST = {DATA_DIG{7'h40}};
    localparam logic [7*ADDR_DIG-1:0]  ADDR_HEX_RST = {ADDR_DIG{7'h40}};

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       scan_addr_q, scan_addr_d;
    logic                    scan_tick_q, scan_tick_d;
    logic [7*DATA_DIG-1:0]   data_hex_q, data_hex_d;
    logic [7*ADDR_DIG-1:0]   addr_hex_q, addr_hex_d;

    logic [ADDR_W-1:0]       disp_addr;
    logic [DATA_W-1:0]       disp_data;
    logic [4*ADDR_DIG-1:0]   disp_addr_pad;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    // Decoding by comparison keeps non-power-of-two DEPTH safe: unmatched addresses read as 0.
    function automatic logic [DATA_W-1:0] read_entry(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) v = mem_q[i];
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] fwd_read(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_en && (wr_addr == a) && in_range(a)) return wr_data;
`endif
        return read_entry(a);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // NOTE: the array is reset because the board must show all zeros after clrn; this forces
    // flip-flop storage instead of a RAM macro, which is acceptable at lab-board depths.
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en && in_range(wr_addr)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == ADDR_W'(i)) mem_q[i] <= wr_data;
            end
        end
    end

    assign rd_data = fwd_read(rd_addr);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d       = '0;
        scan_addr_d = scan_addr_q;
        scan_tick_d = 1'b0;
        if (scan_en) begin
            if (cnt_q == CNT_LAST) begin
                scan_tick_d = 1'b1;
                scan_addr_d = (scan_addr_q == LAST_ADDR) ? '0 : scan_addr_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        disp_addr     = scan_en ? scan_addr_q : rd_addr;
        disp_data     = fwd_read(disp_addr);
        disp_addr_pad = (4*ADDR_DIG)'(disp_addr);
        data_hex_d    = '0;
        addr_hex_d    = '0;
        for (int k = 0; k < DATA_DIG; k++) data_hex_d[7*k +: 7] = seg7(disp_data[4*k +: 4]);
        for (int k = 0; k < ADDR_DIG; k++) addr_hex_d[7*k +: 7] = seg7(disp_addr_pad[4*k +: 4]);
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            cnt_q       <= '0;
            scan_addr_q <= '0;
            scan_tick_q <= 1'b0;
            data_hex_q  <= DATA_HEX_RST;
            addr_hex_q  <= ADDR_HEX_RST;
        end else begin
            cnt_q       <= cnt_d;
            scan_addr_q <= scan_addr_d;
            scan_tick_q <= scan_tick_d;
            data_hex_q  <= data_hex_d;
            addr_hex_q  <= addr_hex_d;
        end
    end

    assign scan_addr = scan_addr_q;
    assign scan_tick = scan_tick_q;
    assign data_hex  = data_hex_q;
    assign addr_hex  = addr_hex_q;

endmodule

// File: tb/tb_regfile_scan_hex.sv
// Bench for regfile_scan_hex: two instances (DEPTH 12 / SCAN_DIV 4 and DEPTH 16 / SCAN_DIV 1)
// share stimulus and are compared every cycle against an array-based model.
module tb_regfile_scan_hex;

    logic        clock = 1'b0;
    logic        clrn;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  rd_addr;
    logic        scan_en;

    logic [7:0]  rd_data_a, rd_data_b;
    logic [3:0]  scan_addr_a, scan_addr_b;
    logic        scan_tick_a, scan_tick_b;
    logic [13:0] data_hex_a, data_hex_b;
    logic [6:0]  addr_hex_a, addr_hex_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_scan_hex #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .SCAN_DIV(4)) u_dut_a (
        .clock(clock), .clrn(clrn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .scan_en(scan_en), .rd_data(rd_data_a), .scan_addr(scan_addr_a),
        .scan_tick(scan_tick_a), .data_hex(data_hex_a), .addr_hex(addr_hex_a)
    );

    regfile_scan_hex #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .SCAN_DIV(1)) u_dut_b (
        .clock(clock), .clrn(clrn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .scan_en(scan_en), .rd_data(rd_data_b), .scan_addr(scan_addr_b),
        .scan_tick(scan_tick_b), .data_hex(data_hex_b), .addr_hex(addr_hex_b)
    );

    // ---------------- reference model ----------------
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0]  m_mem   [2][16];
    int          m_cnt   [2];
    int          m_saddr [2];
    logic        m_tick  [2];
    logic [13:0] m_dhex  [2];
    logic [6:0]  m_ahex  [2];

    function automatic int dep(input int u);
        return (u == 0) ? 12 : 16;
    endfunction

    function automatic int sdiv(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic logic [7:0] m_fwd(input int u, input int a);
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_en && int'(wr_addr) == a && a < dep(u)) return wr_data;
`endif
        return (a < dep(u)) ? m_mem[u][a] : 8'h00;
    endfunction

    function automatic logic [13:0] hex2(input logic [7:0] v);
        return {seg_tab[v[7:4]], seg_tab[v[3:0]]};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 16; i++) m_mem[u][i] = 8'h00;
            m_cnt[u]   = 0;
            m_saddr[u] = 0;
            m_tick[u]  = 1'b0;
            m_dhex[u]  = {7'h40, 7'h40};
            m_ahex[u]  = 7'h40;
        end
    endtask

    always @(posedge clock) begin
        if (clrn) begin
            for (int u = 0; u < 2; u++) begin
                int da;
                da = scan_en ? m_saddr[u] : int'(rd_addr);
                m_dhex[u] = hex2(m_fwd(u, da));
                m_ahex[u] = seg_tab[da[3:0]];
                if (!scan_en) begin
                    m_cnt[u]  = 0;
                    m_tick[u] = 1'b0;
                end else if (m_cnt[u] + 1 == sdiv(u)) begin
                    m_cnt[u]   = 0;
                    m_tick[u]  = 1'b1;
                    m_saddr[u] = (m_saddr[u] + 1) % dep(u);
                end else begin
                    m_cnt[u]  = m_cnt[u] + 1;
                    m_tick[u] = 1'b0;
                end
                if (wr_en && int'(wr_addr) < dep(u)) m_mem[u][wr_addr] = wr_data;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("rd_data_a",   32'(rd_data_a),   32'(m_fwd(0, int'(rd_addr))));
        check("rd_data_b",   32'(rd_data_b),   32'(m_fwd(1, int'(rd_addr))));
        check("scan_addr_a", 32'(scan_addr_a), 32'(m_saddr[0]));
        check("scan_addr_b", 32'(scan_addr_b), 32'(m_saddr[1]));
        check("scan_tick_a", 32'(scan_tick_a), 32'(m_tick[0]));
        check("scan_tick_b", 32'(scan_tick_b), 32'(m_tick[1]));
        check("data_hex_a",  32'(data_hex_a),  32'(m_dhex[0]));
        check("data_hex_b",  32'(data_hex_b),  32'(m_dhex[1]));
        check("addr_hex_a",  32'(addr_hex_a),  32'(m_ahex[0]));
        check("addr_hex_b",  32'(addr_hex_b),  32'(m_ahex[1]));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Called 1 time unit after a rising edge; reset lands mid-cycle and is released mid-cycle.
    task automatic do_reset();
        #2;
        clrn    = 1'b0;
        wr_en   = 1'b0;
        scan_en = 1'b0;
        model_reset();
        @(posedge clock);
        #3;
        clrn = 1'b1;
        step();
    endtask

    initial begin
        clrn    = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        scan_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #3;
        clrn = 1'b1;
        step();

        check("reset data_hex", 32'(data_hex_a), 32'({7'h40, 7'h40}));
        check("reset addr_hex", 32'(addr_hex_a), 32'h40);
        check("reset scan_addr", 32'(scan_addr_a), 32'h0);
        check("reset rd_data", 32'(rd_data_b), 32'h0);

        // Write A5 at 3 and view it
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5; rd_addr = 4'd3;
        step();
        wr_en = 1'b0;
        check("rd A5", 32'(rd_data_a), 32'hA5);
        step();
        check("hex A5", 32'(data_hex_a), 32'({7'h08, 7'h12}));
        check("hex addr 3", 32'(addr_hex_a), 32'h30);

        // Out-of-range write on the 12-deep instance
        wr_en = 1'b1; wr_addr = 4'd13; wr_data = 8'h77; rd_addr = 4'd13;
        step();
        wr_en = 1'b0;
        check("oob rd_a", 32'(rd_data_a), 32'h0);
        check("inrange rd_b", 32'(rd_data_b), 32'h77);

        // Same-cycle read of a location being written
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C; rd_addr = 4'd5;
        #2;
`ifdef REGFILE_WR_BYPASS_EN
        check("bypass rd", 32'(rd_data_a), 32'h3C);
`else
        check("old rd", 32'(rd_data_a), 32'h00);
`endif
        step();
        wr_en = 1'b0;
        check("new rd", 32'(rd_data_a), 32'h3C);

        // Scanner timing from reset
        do_reset();
        scan_en = 1'b1;
        repeat (3) step();
        check("no tick yet", 32'(scan_tick_a), 32'h0);
        step();
        check("tick @4", 32'(scan_tick_a), 32'h1);
        check("addr @4", 32'(scan_addr_a), 32'h1);
        repeat (2) step();
        scan_en = 1'b0;
        repeat (3) step();
        check("held addr", 32'(scan_addr_a), 32'h1);
        check("held tick", 32'(scan_tick_a), 32'h0);
        scan_en = 1'b1;
        repeat (3) step();
        check("resume no tick", 32'(scan_tick_a), 32'h0);
        step();
        check("resume tick", 32'(scan_tick_a), 32'h1);
        check("resume addr", 32'(scan_addr_a), 32'h2);

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 500; i++) begin
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 8'($urandom);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 2) scan_en = ~scan_en;
            if (i == 250) do_reset();
            else step();
        end

        // Fill every entry with addr*0x11, then sweep twice
        scan_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'(a * 8'h11); rd_addr = 4'(a);
            step();
        end
        wr_en = 1'b0; rd_addr = 4'd15;
        #1;
        check("fill rd 15", 32'(rd_data_b), 32'hFF);
        scan_en = 1'b1;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
